// File: rtl/branch_resolve.sv
// branch_resolve: single-stage branch resolution unit with a 2-bit
// saturating-counter branch history table (BHT).
//
// A request (opcode, rt sub-op, operands, PC, offset, fetch prediction) is
// decoded and registered in one cycle. The result carries direction, target,
// link information and a mispredict flag. It is held under output
// back-pressure. Resolved conditional branches train the BHT when their
// result is consumed.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    request handshake
//   in_op, in_rt         opcode and REGIMM sub-op
//   in_a, in_b           rs / rt operand values (DW bits, signed compares)
//   in_pc, in_imm        branch PC and 16-bit word offset
//   in_pred_taken        direction predicted at fetch
//   flush                drop the held result and any incoming request
//   out_valid/out_ready  result handshake
//   out_is_branch, out_taken, out_target, out_link, out_link_addr,
//   out_mispredict       registered resolution result
//   pred_pc, pred_taken  combinational BHT lookup for fetch
module branch_resolve #(
    parameter int DW      = 32,
    parameter int BHT_IDX = 6
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_op,
    input  logic [4:0]    in_rt,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [31:0]   in_pc,
    input  logic [15:0]   in_imm,
    input  logic          in_pred_taken,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_is_branch,
    output logic          out_taken,
    output logic [31:0]   out_target,
    output logic          out_link,
    output logic [31:0]   out_link_addr,
    output logic          out_mispredict,
    input  logic [31:0]   pred_pc,
    output logic          pred_taken
);

    localparam int DEPTH = 1 << BHT_IDX;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    // ------------------------------------------------------------------
    // Condition decode
    // ------------------------------------------------------------------
    logic        a_zero;
    logic        a_neg;
    logic        dec_is_branch;
    logic        dec_taken;
    logic        dec_link;
    logic [31:0] dec_target;

    assign a_zero = (in_a == '0);
    assign a_neg  = in_a[DW-1];

    // Offset is a word count: sign-extend and scale by 4, wrap at 32 bits.
    assign dec_target = in_pc + 32'd4 + {{14{in_imm[15]}}, in_imm, 2'b00};

    // NOTE: every output of a combinational block gets a default before the
    // case; an unassigned path would otherwise infer a latch.
    always_comb begin
        dec_is_branch = 1'b0;
        dec_taken     = 1'b0;
        dec_link      = 1'b0;
        case (in_op)
            OP_BEQ: begin
                dec_is_branch = 1'b1;
                dec_taken     = (in_a == in_b);
            end
            OP_BNE: begin
                dec_is_branch = 1'b1;
                dec_taken     = (in_a != in_b);
            end
            OP_BLEZ: begin
                dec_is_branch = 1'b1;
                dec_taken     = a_neg || a_zero;
            end
            OP_BGTZ: begin
                dec_is_branch = 1'b1;
                dec_taken     = !a_neg && !a_zero;
            end
            OP_REGIMM: begin
                // rt[4] selects the linking variant; rt[0] selects >=0 vs <0.
                case (in_rt)
                    5'b00000, 5'b10000: begin
                        dec_is_branch = 1'b1;
                        dec_taken     = a_neg;
                        dec_link      = in_rt[4];
                    end
                    5'b00001, 5'b10001: begin
                        dec_is_branch = 1'b1;
                        dec_taken     = !a_neg;
                        dec_link      = in_rt[4];
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic               accept;
    logic [BHT_IDX-1:0] held_idx;

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid      <= 1'b0;
            out_is_branch  <= 1'b0;
            out_taken      <= 1'b0;
            out_target     <= '0;
            out_link       <= 1'b0;
            out_link_addr  <= '0;
            out_mispredict <= 1'b0;
            held_idx       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_is_branch  <= dec_is_branch;
            out_taken      <= dec_taken;
            out_target     <= dec_target;
            out_link       <= dec_link;
            out_link_addr  <= in_pc + 32'd8;
            out_mispredict <= dec_is_branch && (dec_taken != in_pred_taken);
            held_idx       <= in_pc[BHT_IDX+1:2];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0] bht [DEPTH];
    logic       bht_upd;

    // Train only when a branch result actually leaves the stage.
    assign bht_upd = out_valid && out_ready && out_is_branch && !flush;

    // NOTE: the table is flop-based and every counter is reset to weakly
    // not-taken, so it cannot map onto a RAM macro without a reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bht <= '{default: 2'b01};
        end else if (bht_upd) begin
            if (out_taken && bht[held_idx] != 2'b11) begin
                bht[held_idx] <= bht[held_idx] + 2'd1;
            end else if (!out_taken && bht[held_idx] != 2'b00) begin
                bht[held_idx] <= bht[held_idx] - 2'd1;
            end
        end
    end

    // Lookup sees the pre-update counter when it collides with a write.
    assign pred_taken = bht[pred_pc[BHT_IDX+1:2]][1];

    logic unused_pred_pc_bits;
    assign unused_pred_pc_bits = ^{pred_pc[31:BHT_IDX+2], pred_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: self-checking bench for branch_resolve. A behavioural
// reference model (resolve function, one held-result slot, integer BHT array)
// predicts every output; directed scenarios plus a randomized run.
module tb_branch_resolve;

    localparam int DW      = 32;
    localparam int BHT_IDX = 6;
    localparam int DEPTH   = 64;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid, in_ready;
    logic [5:0]    in_op;
    logic [4:0]    in_rt;
    logic [DW-1:0] in_a, in_b;
    logic [31:0]   in_pc;
    logic [15:0]   in_imm;
    logic          in_pred_taken, flush;
    logic          out_valid, out_ready;
    logic          out_is_branch, out_taken, out_link, out_mispredict;
    logic [31:0]   out_target, out_link_addr;
    logic [31:0]   pred_pc;
    logic          pred_taken;

    always #5 clk = ~clk;

    branch_resolve #(.DW(DW), .BHT_IDX(BHT_IDX)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rt(in_rt), .in_a(in_a), .in_b(in_b),
        .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_is_branch(out_is_branch), .out_taken(out_taken),
        .out_target(out_target), .out_link(out_link),
        .out_link_addr(out_link_addr), .out_mispredict(out_mispredict),
        .pred_pc(pred_pc), .pred_taken(pred_taken)
    );

    typedef struct packed {
        logic        is_branch;
        logic        taken;
        logic [31:0] target;
        logic        link;
        logic [31:0] link_addr;
        logic        mispredict;
    } res_t;

    logic        m_valid;
    res_t        m_res;
    logic [31:0] m_pc;
    int          m_bht [DEPTH];
    int          n_checks = 0;
    int          n_pass   = 0;

    // ---------------- reference model ----------------
    function automatic res_t model_resolve(logic [5:0] op, logic [4:0] rt,
                                           logic [31:0] a, logic [31:0] b,
                                           logic [31:0] pc, logic [15:0] imm,
                                           logic pred);
        res_t r;
        int   sa;
        int   off;
        r   = '0;
        sa  = $signed(a);
        off = $signed(imm);
        r.target    = pc + 32'd4 + 32'(off * 4);
        r.link_addr = pc + 32'd8;
        case (op)
            6'd4: begin r.is_branch = 1'b1; r.taken = (a == b); end
            6'd5: begin r.is_branch = 1'b1; r.taken = (a != b); end
            6'd6: begin r.is_branch = 1'b1; r.taken = (sa <= 0); end
            6'd7: begin r.is_branch = 1'b1; r.taken = (sa > 0); end
            6'd1: begin
                if (rt == 5'd0 || rt == 5'd16) begin
                    r.is_branch = 1'b1; r.taken = (sa < 0); r.link = (rt == 5'd16);
                end else if (rt == 5'd1 || rt == 5'd17) begin
                    r.is_branch = 1'b1; r.taken = (sa >= 0); r.link = (rt == 5'd17);
                end
            end
            default: ;
        endcase
        r.mispredict = r.is_branch && (r.taken != pred);
        return r;
    endfunction

    function automatic int bht_index(logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic logic model_pred(logic [31:0] pc);
        return m_bht[bht_index(pc)] >= 2;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_res   = '0;
        m_pc    = '0;
        foreach (m_bht[i]) m_bht[i] = 1;
    endtask

    // Advance the model with the inputs currently applied, then clock the DUT.
    task automatic tick();
        logic acc;
        int   idx;
        acc = in_valid && (!m_valid || out_ready) && !flush;
        if (m_valid && out_ready && !flush && m_res.is_branch) begin
            idx = bht_index(m_pc);
            if (m_res.taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else             m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        if (flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_res   = model_resolve(in_op, in_rt, in_a, in_b, in_pc, in_imm, in_pred_taken);
            m_pc    = in_pc;
        end else if (out_ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [68:0] dut_vec();
        res_t r;
        r = {out_is_branch, out_taken, out_target, out_link, out_link_addr, out_mispredict};
        return {out_valid, out_valid ? r : 68'b0};
    endfunction

    function automatic logic [68:0] model_vec();
        return {m_valid, m_valid ? m_res : 68'b0};
    endfunction

    task automatic set_req(logic v, logic [5:0] op, logic [4:0] rt, logic [31:0] a,
                           logic [31:0] b, logic [31:0] pc, logic [15:0] imm, logic pred);
        in_valid = v; in_op = op; in_rt = rt; in_a = a; in_b = b;
        in_pc = pc; in_imm = imm; in_pred_taken = pred;
    endtask

    task automatic rand_req();
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [31:0] a, b;
        logic [31:0] pick [4];
        pick = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
        rt = 5'($urandom);
        case ($urandom_range(0, 7))
            0: op = 6'd4;
            1: op = 6'd5;
            2: op = 6'd6;
            3: op = 6'd7;
            4: begin op = 6'd1; rt = ($urandom_range(0, 1) ? 5'd16 : 5'd0) + 5'($urandom_range(0, 1)); end
            5: op = 6'd1;
            default: op = 6'($urandom);
        endcase
        a = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
        b = ($urandom_range(0, 2) == 0) ? a : $urandom;
        set_req(1'b1, op, rt, a, b, 32'h0040_0000 + 32'($urandom_range(0, 15)) * 32'd4,
                16'($urandom), 1'($urandom));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [68:0] raw;
        pred_pc = 32'h0;
        #1;
        raw = {out_valid, out_is_branch, out_taken, out_target, out_link, out_link_addr, out_mispredict};
        n_checks++;
        if (raw !== 69'b0) $display("FAIL reset_outputs got=%h exp=0", raw); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        n_checks++;
        if (pred_taken !== 1'b0) $display("FAIL reset_pred got=%b exp=0", pred_taken); else n_pass++;
    endtask

    task automatic test_beq();
        logic [34:0] got;
        out_ready = 1'b1;
        set_req(1'b1, 6'b000100, 5'd0, 32'h1234_5678, 32'h1234_5678, 32'h0040_0000, 16'h0004, 1'b0);
        tick();
        n_checks++;
        if (dut_vec() !== model_vec()) $display("FAIL beq_model got=%h exp=%h", dut_vec(), model_vec()); else n_pass++;
        got = {out_valid, out_taken, out_target, out_mispredict};
        n_checks++;
        if (got !== {1'b1, 1'b1, 32'h0040_0014, 1'b1}) $display("FAIL beq_directed got=%h exp=%h", got, {1'b1, 1'b1, 32'h0040_0014, 1'b1}); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL beq_drain got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_bgezal();
        logic [65:0] got;
        out_ready = 1'b1;
        set_req(1'b1, 6'b000001, 5'b10001, 32'h8000_0000, 32'h0, 32'h0, 16'hFFFF, 1'b0);
        tick();
        n_checks++;
        if (dut_vec() !== model_vec()) $display("FAIL bgezal_model got=%h exp=%h", dut_vec(), model_vec()); else n_pass++;
        got = {out_taken, out_link, out_link_addr, out_target};
        n_checks++;
        if (got !== {1'b0, 1'b1, 32'h8, 32'h0}) $display("FAIL bgezal_directed got=%h exp=%h", got, {1'b0, 1'b1, 32'h8, 32'h0}); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        set_req(1'b1, 6'b000101, 5'd0, 32'd7, 32'd9, 32'h100, 16'h0020, 1'b1);
        tick();
        out_ready = 1'b0;
        set_req(1'b1, 6'b000100, 5'd0, 32'd3, 32'd3, 32'h104, 16'hFFF0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); else n_pass++;
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec()); else n_pass++;
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (dut_vec() !== model_vec()) $display("FAIL stall_release got=%h exp=%h", dut_vec(), model_vec()); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_req();
            #1;
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", i, in_ready); else n_pass++;
            tick();
            n_checks++;
            if (dut_vec() !== model_vec() || out_valid !== 1'b1) $display("FAIL b2b_result cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec()); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_bht_sat();
        logic [31:0] p;
        p = 32'h0000_2030;
        pred_pc = p;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0) $display("FAIL bht_initial got=%b exp=0", pred_taken); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            set_req(1'b1, 6'b000101, 5'd0, 32'd1, 32'd2, p, 16'h0010, 1'b0);
            tick();
            in_valid = 1'b0;
            #1;
            // Same-cycle lookup of the index being trained returns the old value.
            n_checks++;
            if (pred_taken !== (k != 0)) $display("FAIL bht_pre_update k=%0d got=%b exp=%b", k, pred_taken, k != 0); else n_pass++;
            tick();
            n_checks++;
            if (pred_taken !== 1'b1 || pred_taken !== model_pred(p)) $display("FAIL bht_post_update k=%0d got=%b exp=1", k, pred_taken); else n_pass++;
        end
        // Two not-taken steps from saturation: 3->2 stays predicted taken, 2->1 flips.
        for (int k = 0; k < 2; k++) begin
            set_req(1'b1, 6'b000101, 5'd0, 32'd5, 32'd5, p, 16'h0010, 1'b1);
            tick();
            in_valid = 1'b0;
            tick();
            n_checks++;
            if (pred_taken !== (k == 0)) $display("FAIL bht_decrement k=%0d got=%b exp=%b", k, pred_taken, k == 0); else n_pass++;
        end
    endtask

    task automatic test_flush();
        logic [31:0] p;
        p = 32'h0000_0050;
        pred_pc = p;
        out_ready = 1'b0;
        set_req(1'b1, 6'b000100, 5'd0, 32'd5, 32'd5, p, 16'h0001, 1'b1);
        tick();
        set_req(1'b1, 6'b000101, 5'd0, 32'd1, 32'd2, p, 16'h0002, 1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", in_ready); else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_clear got=%b exp=0", out_valid); else n_pass++;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_taken !== model_pred(p)) $display("FAIL flush_bht got=%b exp=0", pred_taken); else n_pass++;
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_dropped got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        set_req(1'b1, 6'b000100, 5'd0, 32'd9, 32'd9, 32'h0000_2030, 16'h0003, 1'b0);
        tick();
        out_ready = 1'b0;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_async got=%b exp=0", out_valid); else n_pass++;
        model_reset();
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pred_pc = 32'(i) * 32'd4;
            #1;
            n_checks++;
            if (pred_taken !== 1'b0) $display("FAIL reset_bht idx=%0d got=%b exp=0", i, pred_taken); else n_pass++;
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", in_ready); else n_pass++;
        // One taken update must flip a weakly-not-taken counter to predict taken.
        out_ready = 1'b1;
        set_req(1'b1, 6'b000100, 5'd0, 32'd4, 32'd4, 32'h0000_2030, 16'h0003, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        pred_pc = 32'h0000_2030;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1) $display("FAIL reset_weak_counter got=%b exp=1", pred_taken); else n_pass++;
    endtask

    task automatic test_random();
        logic exp_ready;
        for (int c = 0; c < 400; c++) begin
            rand_req();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            pred_pc   = 32'h0040_0000 + 32'($urandom_range(0, 15)) * 32'd4;
            #1;
            exp_ready = (!m_valid || out_ready) && !flush;
            n_checks++;
            if (in_ready !== exp_ready) $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_ready); else n_pass++;
            n_checks++;
            if (pred_taken !== model_pred(pred_pc)) $display("FAIL rand_pred cyc=%0d got=%b exp=%b", c, pred_taken, model_pred(pred_pc)); else n_pass++;
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL rand_result cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec()); else n_pass++;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        set_req(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0);
        flush = 1'b0;
        out_ready = 1'b0;
        pred_pc = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        test_reset();
        test_beq();
        test_bgezal();
        test_stall();
        test_back_to_back();
        test_bht_sat();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
